aes_ctr_output_buffer: RTL

Downstream of the pipelined AES-CTR core. Captures every 128-bit ciphertext block presented with its valid strobe, since the core has no backpressure. Stores blocks in a DEPTH-entry FIFO and serialises them as 32-bit words for the HPS bridge. Reports drops on overflow, plus level, status and a sticky overflow flag.

---
 rtl/aes_ctr_output_buffer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aes_ctr_output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctr_output_buffer
// Purpose  : Captures 128-bit AES-CTR ciphertext blocks into a DEPTH-entry
//            FIFO and serialises them as 32-bit words for the HPS bridge.
//            The core cannot be stalled, so blocks that arrive when the FIFO
//            is full are dropped and counted. The module also reports level,
//            empty/full status and a sticky overflow flag.
// Option   : AES_OBUF_BYTESWAP_EN - byte-reverse each 32-bit output word so
//            that the first byte of the block appears in rd_data[7:0].
// Revision : 1.0 - initial release
// ============================================================================
module aes_ctr_output_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [127:0]             ct_data,
    input  logic                     ct_valid,
    input  logic                     rd_req,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    input  logic                     flush,
    input  logic                     clear_ovf,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int unsigned      c_AW       = $clog2(DEPTH);
    localparam int unsigned      c_LW       = c_AW + 1;
    localparam logic [c_LW-1:0]  c_LVL_FULL = c_LW'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    logic [127:0]      mem_q [DEPTH];
    logic [c_AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [c_AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [1:0]        word_idx_q, word_idx_d;
    logic [c_LW-1:0]   level_q,    level_d;
    logic [31:0]       rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              is_empty;
    logic              is_full;
    logic              rd_accept;
    logic              pop;
    logic              push;
    logic              drop;
    logic [127:0]      head_blk;
    logic [31:0]       head_word;
    logic [31:0]       out_word;

    assign is_empty  = (level_q == '0);
    assign is_full   = (level_q == c_LVL_FULL);

    // A flush outranks everything that would change FIFO contents this cycle.
    assign rd_accept = rd_req & ~is_empty & ~flush;
    assign pop       = rd_accept & (word_idx_q == 2'd3);
    assign push      = ct_valid & ~flush & (~is_full | pop);
    assign drop      = ct_valid & ~flush & is_full & ~pop;

    assign head_blk  = mem_q[rd_ptr_q];

    // Select the head word combinationally, most significant word first.
    always_comb begin
        head_word = head_blk[127:96];
        case (word_idx_q)
            2'd0:    head_word = head_blk[127:96];
            2'd1:    head_word = head_blk[95:64];
            2'd2:    head_word = head_blk[63:32];
            default: head_word = head_blk[31:0];
        endcase
    end

`ifdef AES_OBUF_BYTESWAP_EN
    assign out_word = {head_word[7:0], head_word[15:8], head_word[23:16], head_word[31:24]};
`else
    assign out_word = head_word;
`endif

    // Next-state computation for pointers, level, read port and drop tracking.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        word_idx_d = word_idx_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            word_idx_d = '0;
            level_d    = '0;
        end else begin
            if (rd_accept) begin
                rd_data_d  = out_word;
                rd_valid_d = 1'b1;
                word_idx_d = word_idx_q + 2'd1;
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
        end

        // A drop in the same cycle as clear_ovf restarts the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_ovf) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != c_CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            word_idx_q <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            word_idx_q <= word_idx_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Block storage; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ct_data;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign level      = level_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule
`default_nettype wire
